complex_div_seq: RTL and testbench
==================================

// Module: complex_div_seq
// PURPOSE
//  Sequential complex divider q = a / b = a*conj(b) / |b|^2, the inverse operation of the combinational
//  complex multiplier in the dotProduct datapath. Accepts signed complex operands via valid/ready, runs
//  one shared restoring-division engine bit-serially, returns fixed-point real/imag quotients.
// PARAMETERS
//  WIDTH  8               operand component width, signed two's complement
//  FRAC   8               fractional bits in quotient
//  OUT_W  WIDTH+FRAC+1    quotient component width, signed, FRAC fractional bits (derived, do not override)
// PORTS
//  clk       in   1       clock, rising edge
//  rst       in   1       asynchronous, active-high reset
//  inValid   in   1       operands valid
//  inReady   out  1       block can accept operands (high only in IDLE)
//  aReal     in   WIDTH   dividend real, signed
//  aImag     in   WIDTH   dividend imag, signed
//  bReal     in   WIDTH   divisor real, signed
//  bImag     in   WIDTH   divisor imag, signed
//  outValid  out  1       result valid, held until outReady
//  outReady  in   1       downstream accepts result
//  outReal   out  OUT_W   quotient real, signed
//  outImag   out  OUT_W   quotient imag, signed
//  divByZero out  1       b == 0 for current result; qualified by outValid
// BEHAVIOUR
//  Reset (async, rst=1): state IDLE, inReady=0 while rst high, outValid=0, outReal=outImag=0, divByZero=0.
//  Accept: inValid & inReady on edge -> operands registered, IDLE->PREP. inReady low outside IDLE.
//  PREP (1 cycle): nR = aR*bR + aI*bI; nI = aI*bR - aR*bI (2*WIDTH+1 signed);
//   den = bR^2 + bI^2 (2*WIDTH+1 unsigned). Store |nR|<<FRAC, |nI|<<FRAC and sign bits.
//   den==0 -> skip DIV, go DONE with outReal=outImag=0, divByZero=1.
//  DIV: ITER = 2*WIDTH+FRAC cycles; each cycle one restoring step on real then imag magnitude
//   (two subtract/compare lanes in parallel, shared counter and den register).
//  SIGN (1 cycle): apply stored signs; truncation toward zero; result always fits OUT_W, no saturation.
//  DONE: outValid=1; outputs and divByZero stable until outValid & outReady, then -> IDLE
//   (inReady high the following cycle). No result overwrite under backpressure.
//  Latency: accept edge to outValid = ITER+3 cycles (27 at defaults); div-by-zero case 2 cycles.
//  Throughput: one division in flight; inValid while busy is ignored (not queued).
//  States: IDLE -> PREP -> DIV -> SIGN -> DONE -> IDLE; PREP -> DONE on den==0.
//  Reset mid-operation: any state -> IDLE immediately, partial result discarded, outputs zeroed.
//  outValid asserted in same cycle as outReady already high: handshake completes on that edge.
// STRUCTURE
//  Shared package: state encoding (IDLE, PREP, DIV, SIGN, DONE, 3-bit), localparam ITER,
//   numerator/den widths as functions of WIDTH/FRAC.
//  Sub-module: udiv_step (one combinational restoring step: remainder, divisor in; next remainder,
//   quotient bit out), instantiated twice (real, imag). Counter, FSM, sign handling in top.
//  Products in PREP reuse existing multi/adderSub cells at 2*WIDTH.
// TESTING (WIDTH=8, FRAC=8, OUT_W=17)
//  a=(3,4), b=(1,2) -> outReal=563 (2.199), outImag=-102 (-0.398), divByZero=0, outValid at cycle 27.
//  a=(-128,-128), b=(1,0) -> outReal=-32768, outImag=-32768 (extreme magnitude, no overflow).
//  a=(-128,0), b=(0,-1) -> outReal=0, outImag=-32768.
//  a=(5,7), b=(0,0) -> divByZero=1, outReal=outImag=0, outValid 2 cycles after accept.
//  Backpressure: outReady low 5 cycles after outValid -> outputs stable, inReady=0, new inValid ignored;
//   outReady=1 -> IDLE, inReady=1 next cycle, next operand pair accepted and correct.
//  rst pulsed mid-DIV -> outValid=0, outputs 0 at once; next transaction a=(3,4), b=(1,2) -> (563,-102).

Source files
------------

// File: rtl/complex_div_seq_pkg.sv
// Shared definitions for the sequential complex divider: FSM state encoding,
// default geometry and the width helpers that tie datapath sizes to WIDTH/FRAC.
package complex_div_seq_pkg;

    // Controller states, 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_DIV  = 3'd2,
        ST_SIGN = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_FRAC  = 8;

    // Signed numerator width: sum of two WIDTH x WIDTH products plus one guard bit
    function automatic int num_w(input int width);
        return 2 * width + 1;
    endfunction

    // Unsigned denominator width: bR^2 + bI^2
    function automatic int den_w(input int width);
        return 2 * width + 1;
    endfunction

    // Scaled numerator magnitude width: |n| fits 2*WIDTH bits, shifted left by FRAC
    function automatic int mag_w(input int width, input int frac);
        return 2 * width + frac;
    endfunction

    // Number of restoring steps: one per bit of the scaled magnitude
    function automatic int iter_n(input int width, input int frac);
        return 2 * width + frac;
    endfunction

    // Signed quotient component width
    function automatic int out_w(input int width, input int frac);
        return width + frac + 1;
    endfunction

    // Counter width able to hold 0 .. n
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int ITER = iter_n(DEF_WIDTH, DEF_FRAC);

endpackage

// File: rtl/complex_div_seq_udiv_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, emit the quotient bit.
// The incoming remainder is always smaller than the divisor, so the outgoing
// remainder fits the same width.
module complex_div_seq_udiv_step
    import complex_div_seq_pkg::*;
#(
    parameter int DEN_W = den_w(DEF_WIDTH)
) (
    input  logic [DEN_W-1:0] rem_i,
    input  logic             bit_i,
    input  logic [DEN_W-1:0] den_i,
    output logic [DEN_W-1:0] rem_o,
    output logic             q_o
);

    logic [DEN_W:0]   trial_s;
    logic [DEN_W+1:0] diff_s;
    logic             fits_s;
    logic             unused_diff_s;

    // Trial subtraction; the extra top bit of diff_s is the borrow
    always_comb begin
        trial_s = {rem_i, bit_i};
        diff_s  = {1'b0, trial_s} - {2'b00, den_i};
        fits_s  = ~diff_s[DEN_W+1];
        if (fits_s) begin
            rem_o = diff_s[DEN_W-1:0];
        end else begin
            rem_o = trial_s[DEN_W-1:0];
        end
        q_o = fits_s;
    end

    // When the subtraction is taken the result is below den, so this bit is always 0
    assign unused_diff_s = diff_s[DEN_W];

endmodule

// File: rtl/complex_div_seq.sv
// Sequential complex divider q = a / b = a*conj(b) / |b|^2.
// Operands are accepted on a valid/ready handshake, the numerator and |b|^2
// are formed in one cycle, then two restoring lanes (real, imag) share one
// step counter and one denominator register, producing one quotient bit per
// cycle each. Signs are re-applied in a final cycle (truncation toward zero).
module complex_div_seq
    import complex_div_seq_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int FRAC  = 8,
    localparam int OUT_W = WIDTH + FRAC + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] aReal,
    input  logic [WIDTH-1:0] aImag,
    input  logic [WIDTH-1:0] bReal,
    input  logic [WIDTH-1:0] bImag,
    output logic             outValid,
    input  logic             outReady,
    output logic [OUT_W-1:0] outReal,
    output logic [OUT_W-1:0] outImag,
    output logic             divByZero
);

    localparam int PROD_W = 2 * WIDTH;
    localparam int ABS_W  = 2 * WIDTH;
    localparam int NUM_W  = num_w(WIDTH);
    localparam int DEN_W  = den_w(WIDTH);
    localparam int MAG_W  = mag_w(WIDTH, FRAC);
    localparam int ITER_N = iter_n(WIDTH, FRAC);
    localparam int CNT_W  = cnt_w(ITER_N);

    // Controller and handshake registers
    state_e             state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [OUT_W-1:0]   out_real_q;
    logic [OUT_W-1:0]   out_imag_q;
    logic               div_by_zero_q;
    logic [CNT_W-1:0]   cnt_q;

    // Operand registers
    logic signed [WIDTH-1:0] a_r_q;
    logic signed [WIDTH-1:0] a_i_q;
    logic signed [WIDTH-1:0] b_r_q;
    logic signed [WIDTH-1:0] b_i_q;

    // Division lanes: the magnitude register shifts dividend bits out at the
    // top and collects quotient bits at the bottom
    logic [MAG_W-1:0]   mag_r_q;
    logic [MAG_W-1:0]   mag_i_q;
    logic [DEN_W-1:0]   rem_r_q;
    logic [DEN_W-1:0]   rem_i_q;
    logic [DEN_W-1:0]   den_q;
    logic               neg_r_q;
    logic               neg_i_q;

    // Combinational datapath
    logic signed [PROD_W-1:0] p_arbr_s;
    logic signed [PROD_W-1:0] p_aibi_s;
    logic signed [PROD_W-1:0] p_aibr_s;
    logic signed [PROD_W-1:0] p_arbi_s;
    logic signed [PROD_W-1:0] p_brbr_s;
    logic signed [PROD_W-1:0] p_bibi_s;
    logic signed [NUM_W-1:0]  nr_s;
    logic signed [NUM_W-1:0]  ni_s;
    logic [DEN_W-1:0]         den_s;
    logic [ABS_W-1:0]         nr_abs_s;
    logic [ABS_W-1:0]         ni_abs_s;
    logic [MAG_W-1:0]         load_r_s;
    logic [MAG_W-1:0]         load_i_s;
    logic [DEN_W-1:0]         rem_r_d;
    logic [DEN_W-1:0]         rem_i_d;
    logic                     qbit_r_s;
    logic                     qbit_i_s;
    logic [MAG_W-1:0]         mag_r_d;
    logic [MAG_W-1:0]         mag_i_d;
    logic [OUT_W-1:0]         res_r_d;
    logic [OUT_W-1:0]         res_i_d;

    // Numerator a*conj(b) and denominator |b|^2 from the registered operands
    always_comb begin
        p_arbr_s = PROD_W'(a_r_q) * PROD_W'(b_r_q);
        p_aibi_s = PROD_W'(a_i_q) * PROD_W'(b_i_q);
        p_aibr_s = PROD_W'(a_i_q) * PROD_W'(b_r_q);
        p_arbi_s = PROD_W'(a_r_q) * PROD_W'(b_i_q);
        p_brbr_s = PROD_W'(b_r_q) * PROD_W'(b_r_q);
        p_bibi_s = PROD_W'(b_i_q) * PROD_W'(b_i_q);
        nr_s     = NUM_W'(p_arbr_s) + NUM_W'(p_aibi_s);
        ni_s     = NUM_W'(p_aibr_s) - NUM_W'(p_arbi_s);
        den_s    = DEN_W'(NUM_W'(p_brbr_s) + NUM_W'(p_bibi_s));
    end

    // Magnitudes of the numerator; |n| <= 2^(2*WIDTH-1) so 2*WIDTH bits suffice
    always_comb begin
        if (nr_s[NUM_W-1]) begin
            nr_abs_s = ~nr_s[ABS_W-1:0] + ABS_W'(1);
        end else begin
            nr_abs_s = nr_s[ABS_W-1:0];
        end
        if (ni_s[NUM_W-1]) begin
            ni_abs_s = ~ni_s[ABS_W-1:0] + ABS_W'(1);
        end else begin
            ni_abs_s = ni_s[ABS_W-1:0];
        end
        load_r_s = {nr_abs_s, {FRAC{1'b0}}};
        load_i_s = {ni_abs_s, {FRAC{1'b0}}};
    end

    complex_div_seq_udiv_step #(
        .DEN_W (DEN_W)
    ) u_step_re (
        .rem_i (rem_r_q),
        .bit_i (mag_r_q[MAG_W-1]),
        .den_i (den_q),
        .rem_o (rem_r_d),
        .q_o   (qbit_r_s)
    );

    complex_div_seq_udiv_step #(
        .DEN_W (DEN_W)
    ) u_step_im (
        .rem_i (rem_i_q),
        .bit_i (mag_i_q[MAG_W-1]),
        .den_i (den_q),
        .rem_o (rem_i_d),
        .q_o   (qbit_i_s)
    );

    // Next lane contents during DIV and the signed results applied in SIGN.
    // The quotient magnitude never exceeds |a|/|b| * 2^FRAC, which fits OUT_W-1 bits.
    always_comb begin
        mag_r_d = {mag_r_q[MAG_W-2:0], qbit_r_s};
        mag_i_d = {mag_i_q[MAG_W-2:0], qbit_i_s};
        if (neg_r_q) begin
            res_r_d = ~mag_r_q[OUT_W-1:0] + OUT_W'(1);
        end else begin
            res_r_d = mag_r_q[OUT_W-1:0];
        end
        if (neg_i_q) begin
            res_i_d = ~mag_i_q[OUT_W-1:0] + OUT_W'(1);
        end else begin
            res_i_d = mag_i_q[OUT_W-1:0];
        end
    end

    // Controller FSM with all datapath state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_real_q    <= {OUT_W{1'b0}};
            out_imag_q    <= {OUT_W{1'b0}};
            div_by_zero_q <= 1'b0;
            cnt_q         <= {CNT_W{1'b0}};
            a_r_q         <= {WIDTH{1'b0}};
            a_i_q         <= {WIDTH{1'b0}};
            b_r_q         <= {WIDTH{1'b0}};
            b_i_q         <= {WIDTH{1'b0}};
            mag_r_q       <= {MAG_W{1'b0}};
            mag_i_q       <= {MAG_W{1'b0}};
            rem_r_q       <= {DEN_W{1'b0}};
            rem_i_q       <= {DEN_W{1'b0}};
            den_q         <= {DEN_W{1'b0}};
            neg_r_q       <= 1'b0;
            neg_i_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (inValid && in_ready_q) begin
                        a_r_q      <= aReal;
                        a_i_q      <= aImag;
                        b_r_q      <= bReal;
                        b_i_q      <= bImag;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_PREP;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                ST_PREP: begin
                    if (den_s == {DEN_W{1'b0}}) begin
                        out_real_q    <= {OUT_W{1'b0}};
                        out_imag_q    <= {OUT_W{1'b0}};
                        div_by_zero_q <= 1'b1;
                        out_valid_q   <= 1'b1;
                        state_q       <= ST_DONE;
                    end else begin
                        mag_r_q <= load_r_s;
                        mag_i_q <= load_i_s;
                        rem_r_q <= {DEN_W{1'b0}};
                        rem_i_q <= {DEN_W{1'b0}};
                        den_q   <= den_s;
                        neg_r_q <= nr_s[NUM_W-1];
                        neg_i_q <= ni_s[NUM_W-1];
                        cnt_q   <= CNT_W'(ITER_N - 1);
                        state_q <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    mag_r_q <= mag_r_d;
                    mag_i_q <= mag_i_d;
                    rem_r_q <= rem_r_d;
                    rem_i_q <= rem_i_d;
                    if (cnt_q == CNT_W'(0)) begin
                        state_q <= ST_SIGN;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_SIGN: begin
                    out_real_q    <= res_r_d;
                    out_imag_q    <= res_i_d;
                    div_by_zero_q <= 1'b0;
                    out_valid_q   <= 1'b1;
                    state_q       <= ST_DONE;
                end
                ST_DONE: begin
                    // Hold the result until the consumer takes it
                    if (outReady) begin
                        out_valid_q   <= 1'b0;
                        div_by_zero_q <= 1'b0;
                        in_ready_q    <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else begin
                        out_valid_q   <= 1'b1;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign inReady   = in_ready_q;
    assign outValid  = out_valid_q;
    assign outReal   = out_real_q;
    assign outImag   = out_imag_q;
    assign divByZero = div_by_zero_q;

endmodule

// File: tb/tb_complex_div_seq.sv
// Directed bench for complex_div_seq at WIDTH=8, FRAC=8 (OUT_W=17).
// Expected quotients are hand-computed: q = a*conj(b)*256/|b|^2, truncated toward zero.
module tb_complex_div_seq;

    localparam int WIDTH = 8;
    localparam int OUT_W = 17;

    logic             clk = 1'b0;
    logic             rst;
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] aReal;
    logic [WIDTH-1:0] aImag;
    logic [WIDTH-1:0] bReal;
    logic [WIDTH-1:0] bImag;
    logic             outValid;
    logic             outReady;
    logic [OUT_W-1:0] outReal;
    logic [OUT_W-1:0] outImag;
    logic             divByZero;

    int n_vec = 0;
    int n_err = 0;
    int lat;

    always #5 clk = ~clk;

    complex_div_seq #(
        .WIDTH (8),
        .FRAC  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .inValid   (inValid),
        .inReady   (inReady),
        .aReal     (aReal),
        .aImag     (aImag),
        .bReal     (bReal),
        .bImag     (bImag),
        .outValid  (outValid),
        .outReady  (outReady),
        .outReal   (outReal),
        .outImag   (outImag),
        .divByZero (divByZero)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present operands at a falling edge and hold until accepted on a rising edge
    task automatic send(input logic [7:0] ar, input logic [7:0] ai, input logic [7:0] br, input logic [7:0] bi);
        int w;
        @(negedge clk);
        aReal = ar; aImag = ai; bReal = br; bImag = bi;
        inValid = 1'b1;
        w = 0;
        while (inReady !== 1'b1 && w < 60) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_before_accept", inReady, 1);
        @(posedge clk);
        #1 inValid = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the accept edge
    task automatic wait_out(output int n);
        n = 1;
        @(negedge clk);
        while (outValid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        rst = 1'b1; inValid = 1'b0; outReady = 1'b0;
        aReal = '0; aImag = '0; bReal = '0; bImag = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_outValid", outValid, 0);
        chk("rst_inReady", inReady, 0);
        chk("rst_outReal", $signed(outReal), 0);
        chk("rst_outImag", $signed(outImag), 0);
        chk("rst_divByZero", divByZero, 0);
        rst = 1'b0;

        // (3+4i)/(1+2i) = (11-2i)/5 -> 563, -102; consumer not yet ready
        send(8'd3, 8'd4, 8'd1, 8'd2);
        wait_out(lat);
        chk("t1_latency", lat, 27);
        chk("t1_outReal", $signed(outReal), 563);
        chk("t1_outImag", $signed(outImag), -102);
        chk("t1_divByZero", divByZero, 0);
        chk("t1_inReady_busy", inReady, 0);
        outReady = 1'b1;
        @(negedge clk);
        chk("t1_outValid_after", outValid, 0);
        chk("t1_inReady_after", inReady, 1);

        // (-128-128i)/1 -> -32768 each; outReady already high
        send(8'h80, 8'h80, 8'd1, 8'd0);
        wait_out(lat);
        chk("t2_latency", lat, 27);
        chk("t2_outReal", $signed(outReal), -32768);
        chk("t2_outImag", $signed(outImag), -32768);
        @(negedge clk);
        chk("t2_outValid_after", outValid, 0);

        // (-128)/(-i) = -128i -> 0, -32768
        send(8'h80, 8'd0, 8'd0, 8'hFF);
        wait_out(lat);
        chk("t3_outReal", $signed(outReal), 0);
        chk("t3_outImag", $signed(outImag), -32768);
        @(negedge clk);

        // Divide by zero
        send(8'd5, 8'd7, 8'd0, 8'd0);
        wait_out(lat);
        chk("t4_latency", lat, 2);
        chk("t4_divByZero", divByZero, 1);
        chk("t4_outReal", $signed(outReal), 0);
        chk("t4_outImag", $signed(outImag), 0);
        @(negedge clk);

        // Backpressure: (-7+3i)/(2-i) = (-17-i)/5 -> -870, -51
        outReady = 1'b0;
        send(8'hF9, 8'd3, 8'd2, 8'hFF);
        wait_out(lat);
        chk("t5_latency", lat, 27);
        aReal = 8'd1; aImag = 8'd1; bReal = 8'd1; bImag = 8'd1;
        inValid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("t5_hold_outValid", outValid, 1);
            chk("t5_hold_outReal", $signed(outReal), -870);
            chk("t5_hold_outImag", $signed(outImag), -51);
            chk("t5_hold_inReady", inReady, 0);
            @(negedge clk);
        end
        inValid = 1'b0;
        outReady = 1'b1;
        @(negedge clk);
        chk("t5_outValid_after", outValid, 0);
        chk("t5_inReady_after", inReady, 1);
        // (1+i)/(1-i) = i -> 0, 256
        send(8'd1, 8'd1, 8'd1, 8'hFF);
        wait_out(lat);
        chk("t5b_latency", lat, 27);
        chk("t5b_outReal", $signed(outReal), 0);
        chk("t5b_outImag", $signed(outImag), 256);
        @(negedge clk);

        // Reset in the middle of DIV
        send(8'd3, 8'd4, 8'd1, 8'd2);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_rst_outValid", outValid, 0);
        chk("t6_rst_outReal", $signed(outReal), 0);
        chk("t6_rst_outImag", $signed(outImag), 0);
        chk("t6_rst_inReady", inReady, 0);
        @(negedge clk);
        rst = 1'b0;
        send(8'd3, 8'd4, 8'd1, 8'd2);
        wait_out(lat);
        chk("t6_latency", lat, 27);
        chk("t6_outReal", $signed(outReal), 563);
        chk("t6_outImag", $signed(outImag), -102);
        chk("t6_divByZero", divByZero, 0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
